// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
// using one full-adder cell with inverted b and a carry preset to 1.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;

    logic             bit_s;
    logic             bit_c;
    logic             nb;
    logic             load;
    logic [WIDTH-1:0] acc_shift;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        load       = 1'b0;

        nb        = ~sb_q[0];
        bit_s     = sa_q[0] ^ nb ^ carry_q;
        bit_c     = (sa_q[0] & nb) | (sa_q[0] & carry_q) | (nb & carry_q);
        // Full result once the last bit lands; its top WIDTH-1 bits are the next partial.
        acc_shift = {bit_s, acc_q};

        case (state_q)
            IDLE: begin
                if (start) load = 1'b1;
            end
            RUN: begin
                acc_d   = acc_shift[WIDTH-1:1];
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = DONE;
                    diff_d     = acc_shift;
                    borrow_d   = ~bit_c;
                    overflow_d = (a_msb_q ^ b_msb_q) & (bit_s ^ a_msb_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                // Accepting here lets a held start issue one operation every WIDTH+1 cycles.
                if (start) load = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = RUN;
            sa_d    = a;
            sb_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
            carry_d = 1'b1;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=32 against an
// arithmetic reference model.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, borrow8, ovf8;
    logic [7:0]  diff8;

    logic        start32;
    logic [31:0] a32, b32;
    logic        busy32, done32, borrow32, ovf32;
    logic [31:0] diff32;

    int pass_cnt;
    int total_cnt;

    logic [31:0] ha [0:34000];
    logic [31:0] hb [0:34000];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32), .borrow(borrow32), .overflow(ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic longint ref_diff(longint av, longint bv, int w);
        longint m;
        m = longint'(1) << w;
        return (av >= bv) ? (av - bv) : (av - bv + m);
    endfunction

    function automatic bit ref_borrow(longint av, longint bv);
        return av < bv;
    endfunction

    function automatic bit ref_ovf(longint av, longint bv, int w);
        longint lim, sa, sb, sd;
        lim = longint'(1) << (w - 1);
        sa  = (av >= lim) ? av - 2 * lim : av;
        sb  = (bv >= lim) ? bv - 2 * lim : bv;
        sd  = sa - sb;
        return (sd >= lim) || (sd < -lim);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 operation; returns cycles to done and busy sample count.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output int busy_n);
        int n;
        n = 0;
        while (busy8 && n < 50) begin
            tick();
            n++;
        end
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        busy_n = 0;
        while (lat < 30) begin
            if (busy8) busy_n++;
            if (done8) break;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        tick();
        tick();
        total_cnt++;
        if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000)
            $display("FAIL reset8: got busy=%b done=%b diff=%0h borrow=%b ovf=%b expected all 0",
                     busy8, done8, diff8, borrow8, ovf8);
        else pass_cnt++;
        total_cnt++;
        if ({busy32, done32, diff32, borrow32, ovf32} !== 36'h0)
            $display("FAIL reset32: got busy=%b done=%b diff=%0h borrow=%b ovf=%b expected all 0",
                     busy32, done32, diff32, borrow32, ovf32);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat, busy_n;
        op8(8'd100, 8'd37, lat, busy_n);
        total_cnt++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat);
        else pass_cnt++;
        total_cnt++;
        if (diff8 !== 8'd63) $display("FAIL basic_diff: got %0d expected 63", diff8);
        else pass_cnt++;
        total_cnt++;
        if ({borrow8, ovf8} !== 2'b00)
            $display("FAIL basic_flags: got borrow=%b ovf=%b expected 0 0", borrow8, ovf8);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy8 !== 1'b0 || busy_n !== 9)
            $display("FAIL basic_busy: got %0d busy cycles (now %b) expected 9 (now 0)", busy_n, busy8);
        else pass_cnt++;
        total_cnt++;
        if (done8 !== 1'b0) $display("FAIL basic_done_pulse: got done=%b expected 0", done8);
        else pass_cnt++;
    endtask

    task automatic test_borrow();
        int lat, busy_n;
        op8(8'd5, 8'd9, lat, busy_n);
        total_cnt++;
        if ({diff8, borrow8, ovf8} !== {8'hFC, 1'b1, 1'b0})
            $display("FAIL borrow_5_9: got diff=%0h borrow=%b ovf=%b expected fc 1 0", diff8, borrow8, ovf8);
        else pass_cnt++;
        op8(8'h5A, 8'h5A, lat, busy_n);
        total_cnt++;
        if ({diff8, borrow8, ovf8} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL borrow_equal: got diff=%0h borrow=%b ovf=%b expected 0 0 0", diff8, borrow8, ovf8);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat, busy_n;
        op8(8'h80, 8'h01, lat, busy_n);
        total_cnt++;
        if ({diff8, borrow8, ovf8} !== {8'h7F, 1'b0, 1'b1})
            $display("FAIL ovf_80_01: got diff=%0h borrow=%b ovf=%b expected 7f 0 1", diff8, borrow8, ovf8);
        else pass_cnt++;
        op8(8'h7F, 8'hFF, lat, busy_n);
        total_cnt++;
        if ({diff8, borrow8, ovf8} !== {8'h80, 1'b1, 1'b1})
            $display("FAIL ovf_7f_ff: got diff=%0h borrow=%b ovf=%b expected 80 1 1", diff8, borrow8, ovf8);
        else pass_cnt++;
    endtask

    task automatic test_random8();
        int lat, busy_n;
        logic [7:0] av, bv;
        for (int i = 0; i < 20; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            op8(av, bv, lat, busy_n);
            total_cnt++;
            if (diff8 !== 8'(ref_diff(av, bv, 8)) || borrow8 !== ref_borrow(av, bv)
                || ovf8 !== ref_ovf(av, bv, 8) || lat !== 8)
                $display("FAIL random8 a=%0h b=%0h: got diff=%0h borrow=%b ovf=%b lat=%0d expected %0h %b %b 8",
                         av, bv, diff8, borrow8, ovf8, lat,
                         8'(ref_diff(av, bv, 8)), ref_borrow(av, bv), ref_ovf(av, bv, 8));
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] av, bv;
        int dones;
        av = 8'($urandom);
        bv = 8'($urandom);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            start8 = (i == 2 || i == 8);
            tick();
        end
        start8 = 1'b0;
        total_cnt++;
        if (done8 !== 1'b1) $display("FAIL ignore_done: got done=%b expected 1", done8);
        else pass_cnt++;
        total_cnt++;
        if (diff8 !== 8'(ref_diff(av, bv, 8)) || borrow8 !== ref_borrow(av, bv) || ovf8 !== ref_ovf(av, bv, 8))
            $display("FAIL ignore_result: got diff=%0h borrow=%b ovf=%b expected %0h %b %b",
                     diff8, borrow8, ovf8, 8'(ref_diff(av, bv, 8)), ref_borrow(av, bv), ref_ovf(av, bv, 8));
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dones++;
        end
        total_cnt++;
        if (dones !== 0 || busy8 !== 1'b0)
            $display("FAIL ignore_extra_done: got %0d dones busy=%b expected 0 dones busy=0", dones, busy8);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int lat, busy_n, dones;
        op8(8'h50, 8'h11, lat, busy_n);
        total_cnt++;
        if (diff8 !== 8'h3F) $display("FAIL abort_prev: got %0h expected 3f", diff8);
        else pass_cnt++;
        tick();
        a8 = 8'hC3;
        b8 = 8'h44;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000)
            $display("FAIL abort_async: got busy=%b done=%b diff=%0h borrow=%b ovf=%b expected all 0",
                     busy8, done8, diff8, borrow8, ovf8);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dones++;
        end
        total_cnt++;
        if (dones !== 0 || diff8 !== 8'h00)
            $display("FAIL abort_no_done: got %0d dones diff=%0h expected 0 dones diff=0", dones, diff8);
        else pass_cnt++;
        op8(8'd20, 8'd3, lat, busy_n);
        total_cnt++;
        if (diff8 !== 8'd17 || lat !== 8)
            $display("FAIL abort_fresh: got diff=%0d lat=%0d expected 17 8", diff8, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int e, ndone, last_done, errs;
        longint av, bv;
        ndone = 0;
        last_done = -1;
        errs = 0;
        a32 = $urandom;
        b32 = $urandom;
        start32 = 1'b1;
        e = 0;
        while (ndone < 1000 && e < 34000) begin
            ha[e] = a32;
            hb[e] = b32;
            tick();
            if (done32) begin
                ndone++;
                total_cnt++;
                if (e < 32) begin
                    $display("FAIL b2b_early_done: got done at edge %0d expected >= 32", e);
                end else begin
                    av = longint'(ha[e-32]);
                    bv = longint'(hb[e-32]);
                    if (diff32 !== 32'(ref_diff(av, bv, 32)) || borrow32 !== ref_borrow(av, bv)
                        || ovf32 !== ref_ovf(av, bv, 32)) begin
                        if (errs < 10)
                            $display("FAIL b2b_result #%0d a=%0h b=%0h: got diff=%0h borrow=%b ovf=%b expected %0h %b %b",
                                     ndone, av, bv, diff32, borrow32, ovf32,
                                     32'(ref_diff(av, bv, 32)), ref_borrow(av, bv), ref_ovf(av, bv, 32));
                        errs++;
                    end else pass_cnt++;
                end
                total_cnt++;
                if ((last_done < 0 && e !== 32) || (last_done >= 0 && e - last_done !== 33))
                    $display("FAIL b2b_spacing #%0d: got done at edge %0d (prev %0d) expected spacing 33",
                             ndone, e, last_done);
                else pass_cnt++;
                last_done = e;
            end
            a32 = $urandom;
            b32 = $urandom;
            e++;
        end
        start32 = 1'b0;
        total_cnt++;
        if (ndone !== 1000) $display("FAIL b2b_count: got %0d dones expected 1000", ndone);
        else pass_cnt++;
        repeat (40) tick();
        total_cnt++;
        if (busy32 !== 1'b0) $display("FAIL b2b_idle: got busy=%b expected 0", busy32);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_random8();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
